// File: rtl/seq_mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and counter sizing.
// Pure declarations; no latency or backpressure of its own.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // One extra bit over log2 so the count never wraps when WIDTH is a power of two.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Start/done request bundle between upstream control and seq_mult.
// Request accepted only while ready=1; no queuing, so a start seen while busy is dropped.
interface seq_mult_if #(
   parameter int WIDTH = 8
);
   import seq_mult_pkg::*;

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 ready;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, a, b,
      input  ready, busy, done, product
   );

   modport slave (
      input  start, a, b,
      output ready, busy, done, product
   );

endinterface

// File: rtl/seq_mult_ctrl.sv
// Multiplier controller: IDLE/RUN/DONE FSM, iteration counter, load/step/finish strobes; WIDTH
// iterations then a one-cycle done pulse (SEQ_MULT_EARLY_TERM_EN stops once the multiplier drains).
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
`ifdef SEQ_MULT_EARLY_TERM_EN
   input  logic i_mplr_drained,
   input  logic i_b_zero,
`endif
   output logic o_load,
   output logic o_step,
   output logic o_finish,
   output logic o_ready,
   output logic o_busy,
   output logic o_done
);

   localparam int              CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic             r_done;
   logic             w_last;
   logic             w_skip;

`ifdef SEQ_MULT_EARLY_TERM_EN
   assign w_last = (r_count == LAST) || i_mplr_drained;
   assign w_skip = i_b_zero;
`else
   assign w_last = (r_count == LAST);
   assign w_skip = 1'b0;
`endif

   assign o_ready  = (r_state == S_IDLE);
   assign o_busy   = ~o_ready;
   assign o_load   = o_ready & i_start;
   assign o_step   = (r_state == S_RUN);
   assign o_finish = (o_step & w_last) | (o_load & w_skip);
   assign o_done   = r_done;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_count <= '0;
                  if (w_skip) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_count <= r_count + 1'b1;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier (datapath + seq_mult_ctrl); product after WIDTH edges, done pulse 1 cycle,
// start ignored unless ready. Optional SEQ_MULT_EARLY_TERM_EN ends as soon as the multiplier shifts to zero.
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   seq_mult_if.slave  io_bus
);

   logic               w_load;
   logic               w_step;
   logic               w_finish;
   logic               w_ready;
   logic               w_busy;
   logic               w_done;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplr;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_product;
   logic [2*WIDTH-1:0] w_acc_next;

`ifdef SEQ_MULT_EARLY_TERM_EN
   logic w_mplr_drained;
   logic w_b_zero;
   assign w_mplr_drained = (r_mplr[WIDTH-1:1] == '0);
   assign w_b_zero       = (io_bus.b == '0);
`endif

   seq_mult_ctrl #(
      .WIDTH          (WIDTH)
   ) u_ctrl (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_start        (io_bus.start),
`ifdef SEQ_MULT_EARLY_TERM_EN
      .i_mplr_drained (w_mplr_drained),
      .i_b_zero       (w_b_zero),
`endif
      .o_load         (w_load),
      .o_step         (w_step),
      .o_finish       (w_finish),
      .o_ready        (w_ready),
      .o_busy         (w_busy),
      .o_done         (w_done)
   );

   // Accumulator is 2*WIDTH wide, so the sum of shifted partial products cannot overflow.
   assign w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mcand   <= '0;
         r_mplr    <= '0;
         r_acc     <= '0;
         r_product <= '0;
      end else begin
         if (w_load) begin
            r_mcand <= {{WIDTH{1'b0}}, io_bus.a};
            r_mplr  <= io_bus.b;
            r_acc   <= '0;
         end else if (w_step) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
         end
         // A finish on the load edge only happens for a zero multiplier.
         if (w_finish) begin
            r_product <= w_load ? '0 : w_acc_next;
         end
      end
   end

   assign io_bus.ready   = w_ready;
   assign io_bus.busy    = w_busy;
   assign io_bus.done    = w_done;
   assign io_bus.product = r_product;

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
Parametrised sequential shift-add multiplier with a start/done handshake. It is the successor to the team's single-bit repeated-addition multiplier datapath/controller pair. It accepts two WIDTH-bit unsigned operands and produces a 2*WIDTH-bit product after WIDTH iterations, one per clock. Upstream control logic drives start and consumes done/product.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits; iteration counter width is derived as $clog2(WIDTH)+1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted only when ready=1
a  input  WIDTH  multiplicand, sampled on the accepting edge
b  input  WIDTH  multiplier, sampled on the accepting edge
ready  output  1  high in IDLE only
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse, registered
product  output  2*WIDTH  result register; holds until next completion

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready=1, busy=0, done=0, product=0, internal acc/shift/count regs=0. Reset in RUN or DONE aborts the operation: no done pulse, product forced to 0.
- States: IDLE, RUN, DONE (3, binary encoded).
- IDLE: on an edge with start=1:
  - mcand <= {WIDTH'0, a}; mplr <= b; acc <= 0; count <= 0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - if mplr[0], acc_next = acc + mcand (2*WIDTH-bit add, never overflows); else acc_next = acc.
  - mcand <<= 1; mplr >>= 1; count++.
  - When count == WIDTH-1 (the WIDTH-th iteration): product <= acc_next; done <= 1; go to DONE.
- DONE: one cycle. On the next edge done <= 0 and state goes to IDLE.
- Latency: the start edge is E0. done is high during the cycle after edge E_WIDTH and low again after E_WIDTH+1. Throughput: one operation per WIDTH+2 cycles.
- start while ready=0 (RUN or DONE): ignored, not queued. a/b changes after acceptance have no effect.
- product changes only on the completing edge, or to 0 on reset. It is valid whenever done=1 and remains stable afterwards.
- Operands of 0 are not special-cased (without the optional feature): the full WIDTH iterations run and product=0.
- ready = (state==IDLE); busy = ~ready. Both are decoded from the state register with no extra latency.

Optional Feature:
Macro SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - In RUN, if the shifted multiplier (mplr>>1) is 0 after the current iteration, that edge completes: product <= acc_next, done <= 1, go to DONE.
  - If b==0 at acceptance, IDLE goes directly to DONE with product <= 0 (done high after E0).
  - Latency = max(1, msb_index(b)+1) edges.
- Undefined: fixed WIDTH-iteration latency as above.
- Product values are identical in both builds.

Decomposition:
- Package seq_mult_pkg holds:
  - the state encoding constants S_IDLE=0, S_RUN=1, S_DONE=2 and the state typedef;
  - a function computing the counter width from WIDTH.
- One sub-module: seq_mult_ctrl (FSM, counter, done/ready/busy generation), emitting load/step/finish strobes to the datapath.
- The datapath (mcand, mplr, acc, product registers and adder) stays in seq_mult, mirroring the existing datapath/controller split.

Test Plan:
- WIDTH=8, a=13, b=11, start pulse at E0 -> done high only in the cycle after E8; product=143; ready returns 1 after E9.
- a=255, b=255 -> product=65025 (0xFE01); no overflow; done width exactly 1 cycle.
- a=0, b=255 and a=200, b=0 -> product=0 both times. Latency is 8 edges, or 8 and 1 edges with SEQ_MULT_EARLY_TERM_EN.
- Start a=3, b=5; at E3 drive start=1 with a=9, b=9 -> second request ignored; product=15; no second done.
- Start a=7, b=7; rst=1 at E4 -> from E4: state IDLE, done never pulses, product=0, ready=1. A fresh start a=6, b=7 then yields 42.
- SEQ_MULT_EARLY_TERM_EN defined, a=100, b=3 -> done after E2, product=300. Back-to-back with b=128 -> done after E8, product=12800.
